// File: rtl/ram_arbiter.sv
// CPU/DMA arbiter for one registered-read RAM: IDLE/ISSUE/RESP FSM with round-robin tie-break.
// Defining RAM_ARB_LOCK_EN lets cpu_lock keep CPU ownership for up to LOCK_MAX consecutive grants.
module ram_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              gnt_cpu,
  output logic              gnt_dma
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t            state_r;
  logic              own_dma_r;
  logic              own_we_r;
  logic              last_dma_r;
  logic [DATA_W-1:0] cpu_hold_r;
  logic [DATA_W-1:0] dma_hold_r;
  logic              any_req_s;
  logic              pick_dma_s;
  logic              lock_hold_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

`ifdef RAM_ARB_LOCK_EN
  localparam int               CNT_W      = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  logic [CNT_W-1:0] lock_cnt_r;

  // CPU keeps the RAM across a tie while it locks and is under the consecutive-grant cap
  always_comb begin
    lock_hold_s = (state_r == RESP) && !own_dma_r && cpu_lock && cpu_req &&
                  (lock_cnt_r < LOCK_MAX_C);
  end

  // Consecutive locked CPU grants; restarts on a DMA grant, an unlocked grant or the cap
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_r <= {CNT_W{1'b0}};
    end else if (any_req_s && (state_r == IDLE || state_r == RESP)) begin
      if (pick_dma_s || !cpu_lock) begin
        lock_cnt_r <= {CNT_W{1'b0}};
      end else if (lock_cnt_r >= LOCK_MAX_C) begin
        lock_cnt_r <= CNT_W'(1'b1);
      end else begin
        lock_cnt_r <= lock_cnt_r + CNT_W'(1'b1);
      end
    end else begin
      lock_cnt_r <= lock_cnt_r;
    end
  end
`else
  logic unused_s;

  // Without the lock feature cpu_lock has no effect
  always_comb begin
    lock_hold_s = 1'b0;
    unused_s    = cpu_lock;
  end
`endif

  // Winner selection and command mux; ties go to whoever was not granted last
  always_comb begin
    any_req_s = cpu_req | dma_req;
    if (cpu_req && dma_req) begin
      pick_dma_s = !last_dma_r && !lock_hold_s;
    end else begin
      pick_dma_s = dma_req;
    end
    if (pick_dma_s) begin
      sel_we_s    = dma_we;
      sel_addr_s  = dma_addr;
      sel_wdata_s = dma_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  // RAM data lands during RESP, so it is passed through while rvalid and held afterwards
  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_hold_r;
  assign dma_rdata = dma_rvalid ? ram_rdata : dma_hold_r;

  // Arbitration FSM with registered strobes, grants and read-data hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      own_dma_r  <= 1'b0;
      own_we_r   <= 1'b0;
      last_dma_r <= 1'b1;
      cpu_hold_r <= {DATA_W{1'b0}};
      dma_hold_r <= {DATA_W{1'b0}};
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= {ADDR_W{1'b0}};
      ram_wdata  <= {DATA_W{1'b0}};
      gnt_cpu    <= 1'b0;
      gnt_dma    <= 1'b0;
    end else begin
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= {ADDR_W{1'b0}};
      ram_wdata  <= {DATA_W{1'b0}};
      if (state_r == RESP && !own_we_r) begin
        if (own_dma_r) begin
          dma_hold_r <= ram_rdata;
        end else begin
          cpu_hold_r <= ram_rdata;
        end
      end
      case (state_r)
        IDLE, RESP: begin
          if (any_req_s) begin
            state_r    <= ISSUE;
            own_dma_r  <= pick_dma_s;
            own_we_r   <= sel_we_s;
            last_dma_r <= pick_dma_s;
            ram_en     <= 1'b1;
            ram_we     <= sel_we_s;
            ram_addr   <= sel_addr_s;
            ram_wdata  <= sel_wdata_s;
            cpu_ack    <= !pick_dma_s;
            dma_ack    <= pick_dma_s;
            gnt_cpu    <= !pick_dma_s;
            gnt_dma    <= pick_dma_s;
          end else begin
            state_r <= IDLE;
            gnt_cpu <= 1'b0;
            gnt_dma <= 1'b0;
          end
        end
        ISSUE: begin
          state_r    <= RESP;
          cpu_rvalid <= !own_we_r && !own_dma_r;
          dma_rvalid <= !own_we_r && own_dma_r;
        end
        default: begin
          state_r <= IDLE;
          gnt_cpu <= 1'b0;
          gnt_dma <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural registered-read RAM.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, cpu_lock;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       dma_req, dma_we;
  logic [3:0] dma_addr;
  logic [7:0] dma_wdata;
  logic       dma_ack, dma_rvalid;
  logic [7:0] dma_rdata;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       gnt_cpu, gnt_dma;
  logic [7:0] mem [16];
  int         n_vec = 0;
  int         n_err = 0;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .gnt_cpu(gnt_cpu), .gnt_dma(gnt_dma)
  );

  always #5 clk = ~clk;

  // RAM macro model: one-cycle registered read
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; cpu_lock = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] outs;
    do_reset();
    outs = {cpu_ack, cpu_rvalid, cpu_rdata, dma_ack, dma_rvalid, dma_rdata,
            ram_en, ram_we, ram_addr, ram_wdata, gnt_cpu, gnt_dma};
    n_vec++;
    if (outs !== 36'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_cpu_write_read();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'hA5;
    step();
    n_vec++;
    if ({cpu_ack, dma_ack, ram_en, ram_we, ram_addr, ram_wdata, gnt_cpu, gnt_dma} !== {4'b1011, 4'd3, 8'hA5, 2'b10}) begin
      n_err++; $display("FAIL wr_issue: ack=%b en=%b we=%b addr=%h wdata=%h gnt=%b%b expected ack=1 en=1 we=1 addr=3 wdata=a5 gnt=10",
                        cpu_ack, ram_en, ram_we, ram_addr, ram_wdata, gnt_cpu, gnt_dma);
    end
    cpu_req = 1'b0;
    step();
    n_vec++;
    if ({cpu_ack, cpu_rvalid, ram_en, ram_we, gnt_cpu, gnt_dma} !== 6'b000010) begin
      n_err++; $display("FAIL wr_resp: got %b expected 000010", {cpu_ack, cpu_rvalid, ram_en, ram_we, gnt_cpu, gnt_dma});
    end
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3; cpu_wdata = 8'h00;
    step();
    n_vec++;
    if ({cpu_ack, ram_en, ram_we, ram_addr, gnt_dma} !== {3'b110, 4'd3, 1'b0}) begin
      n_err++; $display("FAIL rd_issue: ack=%b en=%b we=%b addr=%h gnt_dma=%b expected 1 1 0 3 0",
                        cpu_ack, ram_en, ram_we, ram_addr, gnt_dma);
    end
    cpu_req = 1'b0;
    step();
    n_vec++;
    if ({cpu_rvalid, cpu_rdata, dma_rvalid, gnt_dma} !== {1'b1, 8'hA5, 2'b00}) begin
      n_err++; $display("FAIL rd_resp: rvalid=%b rdata=%h dma_rvalid=%b gnt_dma=%b expected 1 a5 0 0",
                        cpu_rvalid, cpu_rdata, dma_rvalid, gnt_dma);
    end
    step();
    n_vec++;
    if ({cpu_rvalid, cpu_rdata, gnt_cpu} !== {1'b0, 8'hA5, 1'b0}) begin
      n_err++; $display("FAIL rd_hold: rvalid=%b rdata=%h gnt_cpu=%b expected 0 a5 0", cpu_rvalid, cpu_rdata, gnt_cpu);
    end
  endtask

  task automatic test_dma_read();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 4'd9; dma_wdata = 8'h3C;
    step();
    dma_req = 1'b0;
    step();
    step();
    dma_req = 1'b1; dma_we = 1'b0; dma_wdata = 8'h00;
    step();
    n_vec++;
    if ({dma_ack, cpu_ack, gnt_dma, gnt_cpu, ram_en, ram_we, ram_addr} !== {6'b101010, 4'd9}) begin
      n_err++; $display("FAIL dma_issue: got %b expected 101010_1001",
                        {dma_ack, cpu_ack, gnt_dma, gnt_cpu, ram_en, ram_we, ram_addr});
    end
    dma_req = 1'b0;
    step();
    n_vec++;
    if ({dma_rvalid, dma_rdata, cpu_rvalid, cpu_rdata} !== {1'b1, 8'h3C, 1'b0, 8'hA5}) begin
      n_err++; $display("FAIL dma_resp: dma_rvalid=%b dma_rdata=%h cpu_rvalid=%b cpu_rdata=%h expected 1 3c 0 a5",
                        dma_rvalid, dma_rdata, cpu_rvalid, cpu_rdata);
    end
    step();
    n_vec++;
    if ({dma_rvalid, dma_rdata, gnt_dma} !== {1'b0, 8'h3C, 1'b0}) begin
      n_err++; $display("FAIL dma_hold: rvalid=%b rdata=%h gnt=%b expected 0 3c 0", dma_rvalid, dma_rdata, gnt_dma);
    end
  endtask

  task automatic test_withdraw();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd1;
    step();
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 4'd2;
    step();
    dma_req = 1'b0;
    step();
    n_vec++;
    if ({dma_ack, cpu_ack, ram_en, gnt_cpu, gnt_dma} !== 5'b00000) begin
      n_err++; $display("FAIL withdraw: got %b expected 00000", {dma_ack, cpu_ack, ram_en, gnt_cpu, gnt_dma});
    end
    step();
    n_vec++;
    if ({dma_ack, ram_en} !== 2'b00) begin
      n_err++; $display("FAIL withdraw_late: got %b expected 00", {dma_ack, ram_en});
    end
  endtask

  // Both requesters held high; pat bit g = 1 when grant g must go to the DMA
  task automatic run_grants(input logic lock, input logic [9:0] pat, input string tag);
    do_reset();
    cpu_lock = lock;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 4'd2;
    for (int g = 0; g < 10; g++) begin
      step();
      n_vec++;
      if ({cpu_ack, dma_ack, gnt_cpu, gnt_dma, ram_en} !== {!pat[g], pat[g], !pat[g], pat[g], 1'b1}) begin
        n_err++; $display("FAIL %s_issue%0d: ack=%b%b gnt=%b%b en=%b expected ack/gnt cpu=%b dma=%b en=1",
                          tag, g, cpu_ack, dma_ack, gnt_cpu, gnt_dma, ram_en, !pat[g], pat[g]);
      end
      step();
      n_vec++;
      if ({cpu_rvalid, dma_rvalid, cpu_ack, dma_ack, ram_en} !== {!pat[g], pat[g], 3'b000}) begin
        n_err++; $display("FAIL %s_resp%0d: rvalid=%b%b ack=%b%b en=%b expected rvalid cpu=%b dma=%b, rest 0",
                          tag, g, cpu_rvalid, dma_rvalid, cpu_ack, dma_ack, ram_en, !pat[g], pat[g]);
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0; cpu_lock = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    run_grants(1'b0, 10'b10_1010_1010, "tie");
  endtask

  task automatic test_lock();
`ifdef RAM_ARB_LOCK_EN
    run_grants(1'b1, 10'b10_0001_0000, "lock");
`else
    run_grants(1'b1, 10'b10_1010_1010, "lock");
`endif
  endtask

  task automatic test_reset_mid();
    logic [35:0] outs;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd9;
    step();
    n_vec++;
    if (cpu_ack !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_issue: ack=%b expected 1", cpu_ack);
    end
    rst = 1'b1; cpu_req = 1'b0;
    step();
    outs = {cpu_ack, cpu_rvalid, cpu_rdata, dma_ack, dma_rvalid, dma_rdata,
            ram_en, ram_we, ram_addr, ram_wdata, gnt_cpu, gnt_dma};
    n_vec++;
    if (outs !== 36'd0) begin
      n_err++; $display("FAIL rst_mid_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({cpu_rvalid, cpu_ack, ram_en, gnt_cpu} !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_after: got %b expected 0000", {cpu_rvalid, cpu_ack, ram_en, gnt_cpu});
    end
    cpu_req = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 4'd2;
    step();
    n_vec++;
    if ({cpu_ack, dma_ack} !== 2'b10) begin
      n_err++; $display("FAIL rst_mid_tie: ack cpu/dma=%b expected 10", {cpu_ack, dma_ack});
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_wdata = 8'h00; cpu_lock = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 4'd0; dma_wdata = 8'h00;
    test_reset();
    test_cpu_write_read();
    test_dma_read();
    test_withdraw();
    test_back_to_back();
    test_lock();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
